// File: rtl/ahb_cmd_fifo.sv
// rtl/ahb_cmd_fifo.sv - AHB master command FIFO with first-word-fall-through head and replay rewind
module ahb_cmd_fifo #(
  parameter int DATA_W = 67,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int RETAIN = 17
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [DATA_W-1:0] datain,
  input  logic              fifo_writen,
  input  logic              fifo_readen,
  input  logic              tail_back,
  input  logic [4:0]        back_length,
  output logic [DATA_W-1:0] dataout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int LVL_W  = ADDR_W + 1;
  localparam int HIST_W = $clog2(RETAIN + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic [HIST_W-1:0] hist;

  logic              push, pop, pop_empty;
  logic [HIST_W-1:0] amt;
  logic [HIST_W-1:0] hist_inc;

  assign empty = (level_q == '0);
  assign full  = (level_q >= LVL_W'(DEPTH - RETAIN));
  assign level = level_q;

  assign push      = fifo_writen & ~full;
  assign pop       = fifo_readen & ~empty & ~tail_back;
  assign pop_empty = fifo_readen & empty & ~tail_back;

  // Rewind distance is clipped to what the history window actually holds.
  always_comb begin
    amt = '0;
    if (tail_back) begin
      if (HIST_W'(back_length) < hist) amt = HIST_W'(back_length);
      else                             amt = hist;
    end
  end

  assign hist_inc = (hist == HIST_W'(RETAIN)) ? hist : hist + HIST_W'(1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      hist      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= fifo_writen & full;
      underflow <= pop_empty;
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (tail_back) begin
        rd_ptr <= rd_ptr - ADDR_W'(amt);
        hist   <= hist - amt;
      end else if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        hist   <= hist_inc;
      end
      level_q <= level_q + LVL_W'(push) - LVL_W'(pop) + LVL_W'(amt);
    end
  end

  // Storage carries no reset; only slots below level are ever observed.
  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr] <= datain;
  end

  assign dataout = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_ahb_cmd_fifo.sv
// tb/tb_ahb_cmd_fifo.sv - directed self-checking bench for ahb_cmd_fifo
module tb_ahb_cmd_fifo;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [66:0] datain;
  logic        fifo_writen, fifo_readen, tail_back;
  logic [4:0]  back_length;
  logic [66:0] dataout;
  logic        empty, full, overflow, underflow;
  logic [5:0]  level;

  int checks = 0;
  int failures = 0;

  ahb_cmd_fifo dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .datain(datain),
    .fifo_writen(fifo_writen), .fifo_readen(fifo_readen),
    .tail_back(tail_back), .back_length(back_length),
    .dataout(dataout), .empty(empty), .full(full), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [66:0] ent(input logic [2:0] sz, input int i);
    ent = {sz, 32'h1000_0000 + 32'(i * 4), 32'hD000_0000 + 32'(i)};
  endfunction

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle();
    fifo_writen = 1'b0; fifo_readen = 1'b0; tail_back = 1'b0;
    back_length = 5'd0; datain = '0;
  endtask

  task automatic do_reset();
    idle();
    HRESETn = 1'b0;
    #12;
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic push_n(input logic [2:0] sz, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_writen = 1'b1; datain = ent(sz, first + i);
      step();
    end
    fifo_writen = 1'b0;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_readen = 1'b1;
      step();
    end
    fifo_readen = 1'b0;
  endtask

  initial begin
    do_reset();
    // 1: reset state, FWFT ordering, underflow pulse
    check("rst_empty", 67'(empty), 67'd1);
    check("rst_full", 67'(full), 67'd0);
    check("rst_level", 67'(level), 67'd0);
    check("rst_dout", dataout, 67'd0);
    check("rst_ovf_udf", 67'({overflow, underflow}), 67'd0);
    fifo_writen = 1'b1; datain = ent(3'b010, 0);
    step();
    check("t1_empty_after_push", 67'(empty), 67'd0);
    check("t1_dout_A", dataout, ent(3'b010, 0));
    push_n(3'b010, 1, 2);
    check("t1_level3", 67'(level), 67'd3);
    check("t1_head_A", dataout, ent(3'b010, 0));
    fifo_readen = 1'b1;
    step();
    check("t1_pop_B", dataout, ent(3'b010, 1));
    step();
    check("t1_pop_C", dataout, ent(3'b010, 2));
    step();
    check("t1_empty_end", 67'(empty), 67'd1);
    check("t1_dout_zero", dataout, 67'd0);
    step();
    check("t1_udf_pulse", 67'(underflow), 67'd1);
    fifo_readen = 1'b0;
    step();
    check("t1_udf_clear", 67'(underflow), 67'd0);

    // 2: full threshold and dropped push
    do_reset();
    push_n(3'b010, 0, 14);
    check("t2_full_at14", 67'(full), 67'd0);
    push_n(3'b010, 14, 1);
    check("t2_full_at15", 67'(full), 67'd1);
    check("t2_level15", 67'(level), 67'd15);
    push_n(3'b010, 15, 1);
    check("t2_ovf_pulse", 67'(overflow), 67'd1);
    check("t2_level_stays", 67'(level), 67'd15);
    step();
    check("t2_ovf_clear", 67'(overflow), 67'd0);

    // 3: rewind clipped to history
    do_reset();
    push_n(3'b100, 0, 6);
    pop_n(4);
    check("t3_level2", 67'(level), 67'd2);
    check("t3_head4", dataout, ent(3'b100, 4));
    tail_back = 1'b1; back_length = 5'd5;
    step();
    idle();
    check("t3_level6", 67'(level), 67'd6);
    check("t3_head0", dataout, ent(3'b100, 0));

    // 4: history saturates at 17 after 20 pops
    do_reset();
    push_n(3'b010, 0, 10);
    for (int i = 0; i < 10; i++) begin
      fifo_writen = 1'b1; fifo_readen = 1'b1; datain = ent(3'b010, 10 + i);
      step();
    end
    fifo_writen = 1'b0;
    pop_n(10);
    check("t4_empty", 67'(empty), 67'd1);
    tail_back = 1'b1; back_length = 5'd17;
    step();
    idle();
    check("t4_level17", 67'(level), 67'd17);
    check("t4_head3", dataout, ent(3'b010, 3));
    check("t4_full", 67'(full), 67'd1);

    // 5: rewind + pop + push in one cycle, then zero-length rewind
    do_reset();
    push_n(3'b010, 0, 3);
    pop_n(2);
    tail_back = 1'b1; fifo_readen = 1'b1; fifo_writen = 1'b1;
    back_length = 5'd2; datain = ent(3'b010, 9);
    step();
    idle();
    check("t5_level4", 67'(level), 67'd4);
    check("t5_head0", dataout, ent(3'b010, 0));
    check("t5_no_udf", 67'(underflow), 67'd0);
    tail_back = 1'b1; fifo_readen = 1'b1; back_length = 5'd0;
    step();
    idle();
    check("t5_bl0_level", 67'(level), 67'd4);
    check("t5_bl0_head", dataout, ent(3'b010, 0));

    // 6: asynchronous reset mid-cycle
    do_reset();
    push_n(3'b010, 0, 12);
    pop_n(5);
    check("t6_level7", 67'(level), 67'd7);
    #2;
    HRESETn = 1'b0;
    #1;
    check("t6_async_level", 67'(level), 67'd0);
    check("t6_async_empty", 67'(empty), 67'd1);
    check("t6_async_dout", dataout, 67'd0);
    #3;
    HRESETn = 1'b1;
    tail_back = 1'b1; back_length = 5'd5;
    step();
    idle();
    check("t6_hist_cleared", 67'(level), 67'd0);
    push_n(3'b001, 40, 2);
    check("t6_head_after", dataout, ent(3'b001, 40));
    pop_n(1);
    check("t6_pop_after", dataout, ent(3'b001, 41));
    check("t6_level_after", 67'(level), 67'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
